gate_array_pipe: RTL and testbench

Parametrised, registered successor to the single two-input AND gate. It applies one of eight selectable bitwise logic operations to two WIDTH-bit operands, then computes AND/OR/XOR reductions of the result. The operation runs through a two-stage valid/ready pipeline, and the block keeps a count of delivered results. It is the standard logic-operation block for datapaths that need registered, flow-controlled gate functions instead of bare primitives.

---
 rtl/gate_array_pipe.sv | 89 ++++++++
 tb/tb_gate_array_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_array_pipe.sv
// gate_array_pipe: registered two-stage bitwise logic unit
// with reductions, valid/ready flow control and a result counter.
module gate_array_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             red_and,
  output logic             red_or,
  output logic             red_xor,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_count,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] r1;
  logic             v1;
  logic             adv;
  logic             xfer;

  // stall-all: both stages move together or not at all
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign xfer     = out_valid && out_ready;

  // bitwise operation select
  always_comb begin
    f = '0;
    unique case (op)
      3'd0: f = a & b;
      3'd1: f = a | b;
      3'd2: f = a ^ b;
      3'd3: f = ~(a & b);
      3'd4: f = ~(a | b);
      3'd5: f = ~(a ^ b);
      3'd6: f = ~a;
      3'd7: f = a;
    endcase
  end

  // stage 1: capture result, bubble when no input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      r1 <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) r1 <= f;
    end
  end

  // stage 2: output register and reductions
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      red_and   <= 1'b0;
      red_or    <= 1'b0;
      red_xor   <= 1'b0;
    end else if (adv) begin
      out_valid <= v1;
      y         <= r1;
      red_and   <= &r1;
      red_or    <= |r1;
      red_xor   <= ^r1;
    end
  end

  // delivered-result counter; clear beats increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr_count) begin
      count <= '0;
    end else if (xfer) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gate_array_pipe.sv
// tb_gate_array_pipe: scoreboard bench driving WIDTH=8/64/1
// and a CNT_W=4 instance from shared stimulus.
module tb_gate_array_pipe;

  typedef struct packed {
    logic [7:0]  y8;
    logic [63:0] y64;
    logic        y1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [2:0]  op = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        clr_count = 1'b0;

  logic        in_ready, out_valid;
  logic [7:0]  y8;
  logic        ra8, ro8, rx8;
  logic [15:0] count8;

  logic        in_ready64, out_valid64;
  logic [63:0] y64;
  logic        ra64, ro64, rx64;
  logic [15:0] count64;

  logic        in_ready1, out_valid1;
  logic        y1;
  logic        ra1, ro1, rx1;
  logic [15:0] count1;

  logic        in_ready4, out_valid4;
  logic [7:0]  y4;
  logic        ra4, ro4, rx4;
  logic [3:0]  count4;

  int n_vec = 0;
  int n_bad = 0;

  exp_t cur;
  exp_t q[$];
  logic or_q[$];
  logic or_default = 1'b1;
  logic or_rand = 1'b0;

  always #5 clk = ~clk;

  gate_array_pipe #(.WIDTH(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .a(a[7:0]), .b(b[7:0]), .op(op),
    .in_valid(in_valid), .in_ready(in_ready),
    .y(y8), .red_and(ra8), .red_or(ro8),
    .red_xor(rx8), .out_valid(out_valid),
    .out_ready(out_ready),
    .clr_count(clr_count), .count(count8)
  );

  gate_array_pipe #(.WIDTH(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .a(a), .b(b), .op(op),
    .in_valid(in_valid), .in_ready(in_ready64),
    .y(y64), .red_and(ra64), .red_or(ro64),
    .red_xor(rx64), .out_valid(out_valid64),
    .out_ready(out_ready),
    .clr_count(clr_count), .count(count64)
  );

  gate_array_pipe #(.WIDTH(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a(a[0]), .b(b[0]), .op(op),
    .in_valid(in_valid), .in_ready(in_ready1),
    .y(y1), .red_and(ra1), .red_or(ro1),
    .red_xor(rx1), .out_valid(out_valid1),
    .out_ready(out_ready),
    .clr_count(clr_count), .count(count1)
  );

  gate_array_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .a(a[7:0]), .b(b[7:0]), .op(op),
    .in_valid(in_valid), .in_ready(in_ready4),
    .y(y4), .red_and(ra4), .red_or(ro4),
    .red_xor(rx4), .out_valid(out_valid4),
    .out_ready(out_ready),
    .clr_count(clr_count), .count(count4)
  );

  function automatic logic [63:0] fm(
    input logic [2:0] o,
    input logic [63:0] x,
    input logic [63:0] z
  );
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return x ^ z;
      3'd3: return ~(x & z);
      3'd4: return ~(x | z);
      3'd5: return ~(x ^ z);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] req
  );
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // record expectation whenever an input transfer happens
  always @(posedge clk) begin
    if (!rst_n) q.delete();
    else if (in_valid && in_ready) q.push_back(cur);
  end

  // out_ready shaping: pattern queue, random, or default
  always begin
    @(posedge clk);
    #2;
    if (or_q.size() > 0) out_ready = or_q.pop_front();
    else if (or_rand) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = or_default;
  end

  logic        stall_prev = 1'b0;
  logic [7:0]  held8;
  logic [63:0] held64;

  // monitor: handshake rule, stall stability, scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("in_ready_rule", {63'd0, in_ready},
          {63'd0, !out_valid || out_ready});
      if (stall_prev && out_valid) begin
        chk("stall_y8", {56'd0, y8}, {56'd0, held8});
        chk("stall_y64", y64, held64);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_output: y8 %h, none queued",
                   y8);
        end else begin
          e = q.pop_front();
          chk("y8", {56'd0, y8}, {56'd0, e.y8});
          chk("red8", {61'd0, ra8, ro8, rx8},
              {61'd0, &e.y8, |e.y8, ^e.y8});
          chk("y64", y64, e.y64);
          chk("red64", {61'd0, ra64, ro64, rx64},
              {61'd0, &e.y64, |e.y64, ^e.y64});
          chk("y1_red1", {60'd0, y1, ra1, ro1, rx1},
              {60'd0, {4{e.y1}}});
          chk("y4_inst", {53'd0, y4, ra4, ro4, rx4},
              {53'd0, e.y8, &e.y8, |e.y8, ^e.y8});
          chk("ov_agree",
              {61'd0, out_valid64, out_valid1, out_valid4},
              {61'd0, 3'b111});
        end
      end
    end
    stall_prev = rst_n && out_valid && !out_ready;
    held8 = y8;
    held64 = y64;
  end

  task automatic send(
    input logic [63:0] av,
    input logic [63:0] bv,
    input logic [2:0]  o,
    input logic [7:0]  e8
  );
    int n;
    logic [63:0] m;
    m = fm(o, av, bv);
    a = av;
    b = bv;
    op = o;
    cur.y8 = e8;
    cur.y64 = m;
    cur.y1 = m[0];
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        n_vec++;
        n_bad++;
        $display("FAIL send_timeout: in_ready %b want 1",
                 in_ready);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d left want 0",
               q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    clr_count = 1'b1;
    @(posedge clk);
    #1;
    clr_count = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t want finish", $time);
    $fatal(1, "watchdog expired");
  end

  logic [7:0] sweep_exp [8];
  logic [63:0] ra_v, rb_v;

  initial begin
    sweep_exp[0] = 8'h30; sweep_exp[1] = 8'hFC;
    sweep_exp[2] = 8'hCC; sweep_exp[3] = 8'hCF;
    sweep_exp[4] = 8'h03; sweep_exp[5] = 8'h33;
    sweep_exp[6] = 8'h0F; sweep_exp[7] = 8'hF0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov", {63'd0, out_valid}, 64'd0);
    chk("rst_y", {56'd0, y8}, 64'd0);
    chk("rst_red", {61'd0, ra8, ro8, rx8}, 64'd0);
    chk("rst_cnt", {48'd0, count8}, 64'd0);
    rst_n = 1'b1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 8; i++)
      send(64'hF0, 64'h3C, 3'(i), sweep_exp[i]);
    drain();
    chk("sweep_count", {48'd0, count8}, 64'd8);

    send(64'hFF, 64'hFF, 3'd0, 8'hFF);
    send(64'h01, 64'h00, 3'd1, 8'h01);
    drain();

    or_q.push_back(1'b1); or_q.push_back(1'b0);
    or_q.push_back(1'b0); or_q.push_back(1'b1);
    or_q.push_back(1'b0); or_q.push_back(1'b1);
    send(64'h5A, 64'h0F, 3'd2, 8'h55);
    send(64'h5A, 64'h0F, 3'd0, 8'h0A);
    send(64'h5A, 64'h0F, 3'd4, 8'hA0);
    send(64'h5A, 64'h0F, 3'd6, 8'hA5);
    drain();

    clear_counts();
    chk("clr_count4", {60'd0, count4}, 64'd0);
    for (int i = 0; i < 15; i++)
      send(64'(i), 64'h0F, 3'd1, 8'(i) | 8'h0F);
    drain();
    chk("cnt4_15", {60'd0, count4}, 64'd15);
    send(64'h12, 64'h34, 3'd2, 8'h26);
    drain();
    chk("cnt4_wrap0", {60'd0, count4}, 64'd0);
    send(64'hC3, 64'h81, 3'd3, 8'h7E);
    drain();
    chk("cnt4_1", {60'd0, count4}, 64'd1);
    chk("cnt8_17", {48'd0, count8}, 64'd17);

    send(64'h0F, 64'hFF, 3'd5, 8'h0F);
    for (int n = 0; n < 10 && !out_valid; n++)
      @(negedge clk);
    clr_count = 1'b1;
    @(posedge clk);
    #1;
    clr_count = 1'b0;
    chk("clr_wins4", {60'd0, count4}, 64'd0);
    chk("clr_wins8", {48'd0, count8}, 64'd0);
    drain();

    or_default = 1'b0;
    @(posedge clk);
    #1;
    send(64'h11, 64'h22, 3'd1, 8'h33);
    send(64'h11, 64'h22, 3'd0, 8'h00);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_rst_ov", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_y", {56'd0, y8}, 64'd0);
    chk("mid_rst_cnt", {48'd0, count8}, 64'd0);
    chk("mid_rst_ir", {63'd0, in_ready}, 64'd1);
    or_default = 1'b1;
    @(posedge clk);
    #1;
    send(64'hAA, 64'h55, 3'd2, 8'hFF);
    drain();

    clear_counts();
    or_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [63:0] m;
      logic [2:0]  o;
      ra_v = {$urandom, $urandom};
      rb_v = {$urandom, $urandom};
      o = 3'($urandom_range(0, 7));
      m = fm(o, ra_v, rb_v);
      send(ra_v, rb_v, o, m[7:0]);
    end
    or_rand = 1'b0;
    drain();
    chk("rand_cnt8", {48'd0, count8}, 64'd1000);
    chk("rand_cnt64", {48'd0, count64}, 64'd1000);
    chk("rand_cnt1", {48'd0, count1}, 64'd1000);
    chk("rand_cnt4", {60'd0, count4}, 64'd8);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
